// File: rtl/uart_char_rx.sv
// 8N1 serial character receiver with a 2-flop input synchronizer, a held-character flag,
// and sticky framing/overrun error flags for the CPU-side PIO.
module uart_char_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    input  logic       char_ack,
    output logic [7:0] rx_data,
    output logic       char_recv,
    output logic       framing_err,
    output logic       overrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    logic        sync1_q, rxs_q, rxs_d_q;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        char_recv_q, char_recv_d;
    logic        framing_err_q, framing_err_d;
    logic        overrun_q, overrun_d;
    logic        stop_ok, stop_bad;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            IDLE: begin
                if (rxs_d_q && !rxs_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_CNT) begin
                    shift_d[idx_q] = rxs_q;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_CNT) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    stop_ok  = rxs_q;
                    stop_bad = !rxs_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A valid stop always wins over a simultaneous ack; an ack only clears the error flags.
    always_comb begin
        rx_data_d     = rx_data_q;
        char_recv_d   = char_recv_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
        if (stop_ok) begin
            rx_data_d   = shift_q;
            char_recv_d = 1'b1;
            if (char_ack) begin
                overrun_d     = 1'b0;
                framing_err_d = 1'b0;
            end else if (char_recv_q) begin
                overrun_d = 1'b1;
            end
        end else begin
            if (char_ack) begin
                char_recv_d   = 1'b0;
                overrun_d     = 1'b0;
                framing_err_d = 1'b0;
            end
            if (stop_bad) framing_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= 1'b1;
            rxs_q         <= 1'b1;
            rxs_d_q       <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            char_recv_q   <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sync1_q       <= rxd;
            rxs_q         <= sync1_q;
            rxs_d_q       <= rxs_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            char_recv_q   <= char_recv_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign char_recv   = char_recv_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule
